// File: rtl/pressure_calc.sv
// Gas pressure calculator: P = K*n*T/V, computed by a 16-step restoring divider that
// restarts whenever the inputs differ from those captured by the previous run.
module pressure_calc #(
  parameter int unsigned K = 40
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] Q,
  input  logic [2:0] temp,
  input  logic [2:0] numMoles,
  output logic [7:0] pressure,
  output logic       valid,
  output logic       busy,
  output logic       update,
  output logic       saturated
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_t;

  state_t state, stateNext;

  logic [7:0]  qClamp, vol;
  logic [2:0]  tVal, nVal;
  logic [15:0] numer;

  logic [7:0]  snapQ;
  logic [2:0]  snapTemp, snapMoles;
  logic        forceRun;
  logic        change;

  logic [15:0] dividend, quot;
  logic [7:0]  divisor, rem;
  logic [3:0]  bitCnt;

  logic [8:0]  remShift;
  logic [7:0]  remDiff;
  logic        remGe;

  // Operand conditioning from the live inputs; V is never zero.
  always_comb begin
    qClamp = Q;
    if (Q == 8'd0) begin
      qClamp = 8'd1;
    end else if (Q > 8'd200) begin
      qClamp = 8'd200;
    end
    vol   = 8'd201 - qClamp;
    tVal  = (temp > 3'd4) ? 3'd5 : temp + 3'd1;
    nVal  = (numMoles > 3'd5) ? 3'd5 : numMoles;
    numer = 16'(K) * {13'd0, tVal} * {13'd0, nVal};
  end

  assign change = forceRun || (Q != snapQ) || (temp != snapTemp) || (numMoles != snapMoles);
  assign busy   = (state == StDiv) || (state == StDone);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    remShift = {rem, dividend[15]};
    remGe    = (remShift >= {1'b0, divisor});
    remDiff  = 8'(remShift - {1'b0, divisor});
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle: if (change) stateNext = StDiv;
      StDiv:  if (bitCnt == 4'd0) stateNext = StDone;
      StDone: stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Snapshot, divider datapath and registered results.
  always_ff @(posedge clk) begin
    if (clear) begin
      pressure  <= 8'd0;
      saturated <= 1'b0;
      valid     <= 1'b0;
      update    <= 1'b0;
      forceRun  <= 1'b1;
      snapQ     <= 8'd0;
      snapTemp  <= 3'd0;
      snapMoles <= 3'd0;
      dividend  <= 16'd0;
      quot      <= 16'd0;
      divisor   <= 8'd0;
      rem       <= 8'd0;
      bitCnt    <= 4'd0;
    end else begin
      update <= 1'b0;
      unique case (state)
        StIdle: begin
          if (change) begin
            snapQ     <= Q;
            snapTemp  <= temp;
            snapMoles <= numMoles;
            forceRun  <= 1'b0;
            dividend  <= numer;
            divisor   <= vol;
            rem       <= 8'd0;
            quot      <= 16'd0;
            bitCnt    <= 4'd15;
          end
        end
        StDiv: begin
          dividend <= {dividend[14:0], 1'b0};
          rem      <= remGe ? remDiff : remShift[7:0];
          quot     <= {quot[14:0], remGe};
          bitCnt   <= bitCnt - 4'd1;
        end
        StDone: begin
          pressure  <= (quot > 16'd255) ? 8'd255 : quot[7:0];
          saturated <= (quot > 16'd255);
          valid     <= 1'b1;
          update    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_calc.sv
// Self-checking bench for pressure_calc against an arithmetic reference model.
module tb_pressure_calc;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] Q = 8'd0;
  logic [2:0] temp = 3'd0;
  logic [2:0] numMoles = 3'd0;
  logic [7:0] pressure;
  logic       valid, busy, update, saturated;

  int checks = 0;
  int errors = 0;

  pressure_calc #(.K(40)) dut (
    .clk(clk), .clear(clear), .Q(Q), .temp(temp), .numMoles(numMoles),
    .pressure(pressure), .valid(valid), .busy(busy), .update(update), .saturated(saturated)
  );

  always #5 clk = ~clk;

  // Exact quotient of K*n*T/V from the clamping rules.
  function automatic int ref_quot(input int q, input int t, input int m);
    int qc, v, tt, nn;
    qc = (q < 1) ? 1 : ((q > 200) ? 200 : q);
    v  = 201 - qc;
    tt = ((t > 4) ? 4 : t) + 1;
    nn = (m > 5) ? 5 : m;
    return (40 * nn * tt) / v;
  endfunction

  function automatic int ref_p(input int q, input int t, input int m);
    int x;
    x = ref_quot(q, t, m);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic drive(input int q, input int t, input int m);
    Q = 8'(q);
    temp = 3'(t);
    numMoles = 3'(m);
  endtask

  // Counts negedges until update is seen; -1 on timeout.
  task automatic wait_update(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (update) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic run_case(input string name, input int q, input int t, input int m);
    int n, expP, expS;
    expP = ref_p(q, t, m);
    expS = (ref_quot(q, t, m) > 255) ? 1 : 0;
    drive(q, t, m);
    wait_update(n);
    checks++;
    if (n !== 18) begin
      errors++;
      $display("FAIL %s latency got %0d need 18", name, n);
    end
    checks++;
    if (pressure !== 8'(expP)) begin
      errors++;
      $display("FAIL %s pressure got %0d need %0d", name, pressure, expP);
    end
    checks++;
    if (saturated !== 1'(expS)) begin
      errors++;
      $display("FAIL %s saturated got %0b need %0b", name, saturated, expS);
    end
  endtask

  task automatic test_reset;
    bit seen;
    clear = 1'b1;
    drive(161, 0, 1);
    repeat (2) @(negedge clk);
    checks++;
    if ({pressure, valid, busy, update, saturated} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got p=%0d v=%0b b=%0b u=%0b s=%0b need all 0",
               pressure, valid, busy, update, saturated);
    end
    clear = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL first_busy got %0b need 1", busy);
        end
      end
      if (i < 18 && (update || valid)) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL early_update got 1 need 0 before edge 17");
    end
    checks++;
    if (update !== 1'b1 || valid !== 1'b1 || pressure !== 8'd1 || saturated !== 1'b0) begin
      errors++;
      $display("FAIL first_result got u=%0b v=%0b p=%0d s=%0b need u=1 v=1 p=1 s=0",
               update, valid, pressure, saturated);
    end
    @(negedge clk);
    checks++;
    if (update !== 1'b0 || busy !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL after_result got u=%0b b=%0b v=%0b need u=0 b=0 v=1", update, busy, valid);
    end
  endtask

  task automatic test_boundary;
    run_case("bnd_q1", 1, 4, 5);
    run_case("bnd_q200", 200, 0, 1);
    run_case("bnd_trunc", 121, 2, 3);
  endtask

  task automatic test_saturation;
    run_case("sat_hi", 200, 4, 5);
    run_case("sat_back", 1, 4, 5);
  endtask

  task automatic test_clamping;
    run_case("clamp_q0", 0, 4, 5);
    run_case("clamp_q250", 250, 0, 1);
    run_case("clamp_t7", 1, 7, 5);
    run_case("clamp_n0", 1, 7, 0);
  endtask

  task automatic test_random;
    int q, t, m, lq, lt, lm;
    lq = 1; lt = 7; lm = 0;
    for (int i = 0; i < 20; i++) begin
      q = $urandom_range(255);
      t = $urandom_range(7);
      m = $urandom_range(7);
      if (q == 100) q = 101;
      if (q == lq && t == lt && m == lm) q = (q == 255) ? 0 : q + 1;
      run_case($sformatf("rand%0d", i), q, t, m);
      lq = q; lt = t; lm = m;
    end
  endtask

  task automatic test_back_to_back;
    int first, second, extra;
    first = -1; second = -1; extra = 0;
    drive(100, 3, 2);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 5) Q = 8'd50;
      if (update) begin
        if (first < 0) begin
          first = i;
          checks++;
          if (pressure !== 8'(ref_p(100, 3, 2))) begin
            errors++;
            $display("FAIL midrun_old got %0d need %0d", pressure, ref_p(100, 3, 2));
          end
        end else if (second < 0) begin
          second = i;
          checks++;
          if (pressure !== 8'(ref_p(50, 3, 2))) begin
            errors++;
            $display("FAIL midrun_new got %0d need %0d", pressure, ref_p(50, 3, 2));
          end
        end else begin
          extra++;
        end
      end
    end
    checks++;
    if (first !== 18 || second !== 36) begin
      errors++;
      $display("FAIL midrun_timing got %0d,%0d need 18,36", first, second);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midrun_extra got %0d need 0", extra);
    end
  endtask

  task automatic test_clear_midrun;
    bit seenUpd;
    seenUpd = 1'b0;
    drive(30, 1, 4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (update) seenUpd = 1'b1;
      if (i == 8) clear = 1'b1;
    end
    @(negedge clk);
    if (update) seenUpd = 1'b1;
    checks++;
    if ({pressure, valid, busy, update, saturated} !== 12'd0) begin
      errors++;
      $display("FAIL clear_midrun got p=%0d v=%0b b=%0b u=%0b s=%0b need all 0",
               pressure, valid, busy, update, saturated);
    end
    checks++;
    if (seenUpd) begin
      errors++;
      $display("FAIL clear_noupdate got 1 need 0");
    end
    clear = 1'b0;
    run_case("clear_rerun", 30, 1, 4);
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_saturation();
    test_clamping();
    test_random();
    test_back_to_back();
    test_clear_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pressure_calc.md
# pressure_calc

Downstream consumer of the piston-position counter. Takes the current piston position (`Q`, 1..200), temperature index and mole count, and computes the displayed gas pressure P = K·n·T / V. It uses a multi-cycle restoring divider that starts whenever any input changes. The registered 8-bit result feeds the pressure gauge and display logic.

## Interface
- `K`, default 40: gas-constant scale factor, legal range 1..255.
- `clk` in 1: system clock; every register updates on the rising edge.
- `clear` in 1: reset, synchronous and active-high.
- `Q` in 8: piston position from the border counter; 1 is fully expanded, 200 is fully compressed.
- `temp` in 3: temperature index, 0..4.
- `numMoles` in 3: mole count, 1..5.
- `pressure` out 8: last computed pressure, saturated to 255.
- `valid` out 1: high once the first result since reset has been written; stays high after that.
- `busy` out 1: high while a computation is in flight (states DIV and DONE).
- `update` out 1: one-cycle pulse on the cycle `pressure` takes a new value.
- `saturated` out 1: registered with `pressure`; high when the true quotient exceeded 255.

## Operation
- **Operand conditioning** (combinational, from live inputs):
  - V = 201 − Qc, where Qc = Q clamped to 1..200. Q=0 is treated as 1; Q>200 is treated as 200. V is therefore 1..200 and never 0.
  - T = min(temp, 4) + 1, range 1..5.
  - n = min(numMoles, 5). n=0 is legal and yields a pressure of 0.
  - N = K·n·T, computed at 16 bits; the maximum is 255·25 = 6375, so there is no overflow.
- **Snapshot:** registers hold Q, temp and numMoles as captured at the start of the current or last run.
  - A `force` flag is set by `clear` and cleared at capture.
  - `change` = force OR (any live input ≠ its snapshot).
- **FSM states:** IDLE, DIV, DONE.
  - IDLE: if `change`, capture the snapshot, load the dividend with N, the divisor with V, the remainder with 0 and the bit counter with 15; go to DIV. Otherwise stay in IDLE.
  - DIV: one restoring-division step per cycle, MSB first. Shift the remainder left by 1 and bring in the next dividend bit. If remainder ≥ V, subtract V and set the quotient bit. After 16 steps (counter reaches 0), go to DONE.
  - DONE: pressure ← (quotient > 255) ? 255 : quotient[7:0]; saturated ← (quotient > 255); valid ← 1; update ← 1; go to IDLE.
- **Input changes during DIV/DONE** are ignored by the current run. Because the snapshot then differs from the live inputs, the next IDLE cycle starts a new run. Intermediate input values are never reported; only the inputs present at a capture are.
- `pressure` and `saturated` hold their previous values throughout a run.
- Division truncates toward zero.

## Timing
- **Reset values** (`clear`=1 at an edge): state=IDLE, pressure=0, saturated=0, valid=0, busy=0, update=0, force=1, snapshot=0.
- **`clear` mid-run** aborts the division immediately; the partial result is discarded. The outputs take their reset values.
- **First run after reset:** the first edge with `clear`=0 is the capture edge E0, because force=1.
- **Latency:**
  - E0 is the capture edge (IDLE→DIV).
  - E1..E16 are the 16 divide steps; E16 moves to DONE.
  - E17 writes `pressure`; `update`=1 for the cycle after E17; the FSM returns to IDLE.
  - Total: 17 edges from capture to result.
- **Back-to-back runs:** with inputs changing every cycle, the earliest next capture is E18, so results arrive every 18 cycles.
- **`busy`:** high from after E0 until after E17.
- **`update`:** exactly one cycle per completed run, and never asserted while `clear`=1.

## Test plan
- **Reset and first result:** `clear` pulse, then K=40, Q=161, temp=0, numMoles=1 → N=40, V=40. Expect pressure=1, saturated=0, valid rising, and `update` 17 edges after the first non-clear edge.
- **Boundary values:**
  - Q=1, temp=4, numMoles=5 → 1000/200 = 5.
  - Q=200, temp=0, numMoles=1 → 40/1 = 40.
  - Q=121, temp=2, numMoles=3 → 360/80 = 4 (truncated).
- **Saturation:** Q=200, temp=4, numMoles=5 → quotient 1000; expect pressure=255, saturated=1. Then Q=1 → pressure=5, saturated=0.
- **Clamping:**
  - Q=0 gives the same result as Q=1.
  - Q=250 gives the same result as Q=200.
  - temp=7 gives the same result as temp=4.
  - numMoles=0 → pressure=0.
- **Mid-run input change:** change Q at E5 of a run. Expect the E17 result to reflect the old Q, and a second capture at E18 with its result at E35. Hold the inputs stable afterwards and check that no further `update` occurs.
- **Reset mid-run:** assert `clear` at E8. Expect all outputs at reset values on the next cycle and no `update`. Release `clear` and check that a full 17-edge run completes with the correct value.
